coherency_bus_ctrl: RTL and testbench

- Parametrised successor to the fixed 4-core coherency bus: N-core round-robin arbiter plus full transaction sequencer.
- Broadcasts snoops, collects snoop hit/supply responses and sources the line from an owning cache (cache-to-cache) or from shared_memory.
- Returns data to the requester.
- Sits between the cache_controller array and shared_memory in the MOESI top level.

---
 rtl/coherency_bus_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_coherency_bus_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/coherency_bus_ctrl.sv
// N-core coherency bus: round-robin grant, snoop broadcast, c2c or memory sourcing, response.
// Optional perf counters when COH_BUS_PERF_EN is defined.
module coherency_bus_ctrl #(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int SNOOP_LAT  = 2,
  parameter int CORE_ID_W  = $clog2(NUM_CORES)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_CORES-1:0]                  req_valid,
  input  logic [NUM_CORES-1:0][1:0]             req_type,
  input  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0]  req_addr,
  output logic [NUM_CORES-1:0]                  req_ready,
  output logic                                  bus_valid,
  output logic [1:0]                            bus_type,
  output logic [ADDR_WIDTH-1:0]                 bus_addr,
  output logic [CORE_ID_W-1:0]                  bus_src_id,
  input  logic [NUM_CORES-1:0]                  snoop_hit,
  input  logic [NUM_CORES-1:0]                  snoop_supply,
  input  logic [NUM_CORES-1:0][DATA_WIDTH-1:0]  snoop_data,
  output logic                                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0]                 mem_req_addr,
  input  logic                                  mem_req_ready,
  input  logic                                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]                 mem_resp_rdata,
  output logic [NUM_CORES-1:0]                  resp_valid,
  output logic [DATA_WIDTH-1:0]                 resp_data,
  output logic                                  resp_shared,
  output logic                                  err_multi_owner,
  output logic [31:0]                           perf_txn,
  output logic [31:0]                           perf_c2c
);
  localparam int CNT_W = (SNOOP_LAT > 1) ? $clog2(SNOOP_LAT) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SNOOP_LAT - 1);
  localparam logic [CORE_ID_W:0]   NC       = (CORE_ID_W+1)'(NUM_CORES);
  localparam logic [CORE_ID_W-1:0] LAST_ID  = CORE_ID_W'(NUM_CORES - 1);

  typedef enum logic [2:0] {IDLE, BCAST, SNOOP, MEM_REQ, MEM_WAIT, RESP} state_t;
  typedef struct packed {
    logic [1:0]            typ;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CORE_ID_W-1:0]  src;
  } txn_t;

  state_t                state, nxt;
  txn_t                  txn;
  logic [CORE_ID_W-1:0]  ptr, gnt_idx, sel, cand;
  logic [CORE_ID_W:0]    sum;
  logic                  gnt_found, shared_q, c2c_q, multi, snoop_done;
  logic [CNT_W-1:0]      cnt;
  logic [NUM_CORES-1:0]  own_mask, sup_m, hit_m;

  // Round-robin scan with mod-NUM_CORES wrap (safe for non-power-of-2 core counts)
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      sum = {1'b0, ptr} + (CORE_ID_W+1)'(i);
      if (sum >= NC) sum = sum - NC;
      cand = sum[CORE_ID_W-1:0];
      if (!gnt_found && req_valid[cand] && req_type[cand] != 2'b00) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    own_mask = ~(NUM_CORES'(1) << txn.src);
    sup_m    = snoop_supply & own_mask;
    hit_m    = snoop_hit & own_mask;
    multi    = (sup_m & (sup_m - NUM_CORES'(1))) != '0;
    sel      = '0;
    for (int i = NUM_CORES-1; i >= 0; i--)
      if (sup_m[i]) sel = CORE_ID_W'(i);
  end

  assign snoop_done = (state == SNOOP) && (cnt == CNT_LAST);

  always_comb begin
    nxt           = state;
    req_ready     = '0;
    bus_valid     = 1'b0;
    bus_type      = '0;
    bus_addr      = '0;
    bus_src_id    = '0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    resp_valid    = '0;
    resp_shared   = 1'b0;
    case (state)
      IDLE: if (gnt_found) begin
        req_ready[gnt_idx] = 1'b1;
        nxt = BCAST;
      end
      BCAST: begin
        bus_valid  = 1'b1;
        bus_type   = txn.typ;
        bus_addr   = txn.addr;
        bus_src_id = txn.src;
        nxt        = SNOOP;
      end
      SNOOP: if (snoop_done)
        nxt = (txn.typ == 2'b11 || sup_m != '0) ? RESP : MEM_REQ;
      MEM_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = txn.addr;
        if (mem_req_ready) nxt = MEM_WAIT;
      end
      MEM_WAIT: if (mem_resp_valid) nxt = RESP;
      RESP: begin
        resp_valid[txn.src] = 1'b1;
        resp_shared         = shared_q;
        nxt                 = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= '0;
      txn             <= '0;
      cnt             <= '0;
      resp_data       <= '0;
      shared_q        <= 1'b0;
      c2c_q           <= 1'b0;
      err_multi_owner <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (gnt_found) begin
          txn <= '{typ: req_type[gnt_idx], addr: req_addr[gnt_idx], src: gnt_idx};
          ptr <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
        end
        BCAST: cnt <= '0;
        SNOOP: if (snoop_done) begin
          // Exclusive requests never leave another copy behind
          shared_q <= (txn.typ == 2'b01) && (hit_m != '0);
          if (multi) err_multi_owner <= 1'b1;
          if (txn.typ == 2'b11) begin
            resp_data <= '0;
            c2c_q     <= 1'b0;
          end else if (sup_m != '0) begin
            resp_data <= snoop_data[sel];
            c2c_q     <= 1'b1;
          end else begin
            c2c_q     <= 1'b0;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
        MEM_WAIT: if (mem_resp_valid) resp_data <= mem_resp_rdata;
        default: ;
      endcase
    end
  end

`ifdef COH_BUS_PERF_EN
  logic [31:0] txn_cnt, c2c_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_cnt <= '0;
      c2c_cnt <= '0;
    end else if (state == RESP) begin
      txn_cnt <= txn_cnt + 32'd1;
      if (c2c_q) c2c_cnt <= c2c_cnt + 32'd1;
    end
  end
  assign perf_txn = txn_cnt;
  assign perf_c2c = c2c_cnt;
`else
  assign perf_txn = '0;
  assign perf_c2c = '0;
`endif
endmodule

// File: tb/tb_coherency_bus_ctrl.sv
// Randomized bench for coherency_bus_ctrl against a transaction-level reference model.
module tb_coherency_bus_ctrl;
  localparam int N = 4, AW = 64, DW = 512, SL = 2, IW = 2;

  logic clk = 1'b0, rst;
  always #5 clk = ~clk;

  logic [N-1:0]          req_valid, req_ready, snoop_hit, snoop_supply, resp_valid;
  logic [N-1:0][1:0]     req_type;
  logic [N-1:0][AW-1:0]  req_addr;
  logic [N-1:0][DW-1:0]  snoop_data;
  logic                  bus_valid, mem_req_valid, mem_req_ready, mem_resp_valid;
  logic                  resp_shared, err_multi_owner;
  logic [1:0]            bus_type;
  logic [AW-1:0]         bus_addr, mem_req_addr;
  logic [IW-1:0]         bus_src_id;
  logic [DW-1:0]         mem_resp_rdata, resp_data;
  logic [31:0]           perf_txn, perf_c2c;

  coherency_bus_ctrl #(.NUM_CORES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SNOOP_LAT(SL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_type(req_type), .req_addr(req_addr),
    .req_ready(req_ready), .bus_valid(bus_valid), .bus_type(bus_type), .bus_addr(bus_addr),
    .bus_src_id(bus_src_id), .snoop_hit(snoop_hit), .snoop_supply(snoop_supply),
    .snoop_data(snoop_data), .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_shared(resp_shared), .err_multi_owner(err_multi_owner),
    .perf_txn(perf_txn), .perf_c2c(perf_c2c));

  int n_chk = 0, n_fail = 0;
  int ptr_m = 0, txn_m = 0, c2c_m = 0;
  logic err_m = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_line(input logic [AW-1:0] a);
    return {16{a[31:0] ^ 32'h5A5A_0F0F}};
  endfunction

  task automatic chk_perf();
`ifdef COH_BUS_PERF_EN
    chk("perf_txn", perf_txn, txn_m);
    chk("perf_c2c", perf_c2c, c2c_m);
`else
    chk("perf_txn_off", perf_txn, 0);
    chk("perf_c2c_off", perf_c2c, 0);
`endif
  endtask

  task automatic run_txn(input logic [N-1:0] v, input logic [N-1:0][1:0] ty,
                         input logic [N-1:0][AW-1:0] ad, input logic [N-1:0] hit,
                         input logic [N-1:0] sup, input logic [N-1:0][DW-1:0] sd);
    int k, lat, cyc, accepts, ones;
    logic [N-1:0] supm, hitm;
    logic [DW-1:0] exp_d;
    logic exp_sh, exp_mem, got, mem_busy, is_c2c;
    logic [AW-1:0] maddr;
    k = -1;
    for (int i = 0; i < N; i++) begin
      int j;
      j = (ptr_m + i) % N;
      if (k < 0 && v[j] && ty[j] != 2'b00) k = j;
    end
    @(negedge clk);
    req_valid = v; req_type = ty; req_addr = ad;
    snoop_hit = hit; snoop_supply = sup; snoop_data = sd;
    #1;
    chk("grant", req_ready, N'(1) << k);
    ptr_m = (k + 1) % N;
    @(negedge clk);
    req_valid = '0;
    chk("bus_valid", bus_valid, 1);
    chk("bus_type", bus_type, ty[k]);
    chk("bus_addr", bus_addr, ad[k]);
    chk("bus_src", bus_src_id, k);

    supm = sup & ~(N'(1) << k);
    hitm = hit & ~(N'(1) << k);
    ones = $countones(supm);
    if (ones > 1) err_m = 1'b1;
    exp_sh = (ty[k] == 2'b01) && (hitm != 0);
    is_c2c = 1'b0; exp_mem = 1'b0;
    if (ty[k] == 2'b11) exp_d = '0;
    else if (supm != 0) begin
      is_c2c = 1'b1;
      exp_d = '0;
      for (int i = N-1; i >= 0; i--) if (supm[i]) exp_d = sd[i];
    end else begin
      exp_mem = 1'b1;
      exp_d = mem_line(ad[k]);
    end

    got = 1'b0; mem_busy = 1'b0; accepts = 0; lat = 0; maddr = '0;
    for (cyc = 2; cyc < 100 && !got; cyc++) begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (mem_busy) begin
        lat--;
        if (lat == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = mem_line(maddr);
          mem_busy = 1'b0;
        end
      end
      mem_req_ready = 1'b0;
      if (mem_req_valid) begin
        chk("mem_addr", mem_req_addr, ad[k]);
        mem_req_ready = 1'($urandom % 2);
        if (mem_req_ready) begin
          accepts++; mem_busy = 1'b1; maddr = mem_req_addr; lat = $urandom_range(1, 4);
        end
      end
      if (resp_valid != 0) begin
        got = 1'b1;
        chk("resp_valid", resp_valid, N'(1) << k);
        chk("resp_data", resp_data, exp_d);
        chk("resp_shared", resp_shared, exp_sh);
        if (!exp_mem) chk("resp_latency", cyc, SL + 2);
      end
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    if (!got) chk("resp_timeout", 0, 1);
    chk("mem_accepts", accepts, exp_mem ? 1 : 0);
    txn_m++;
    if (is_c2c) c2c_m++;
    @(negedge clk);
    chk("err_multi_owner", err_multi_owner, err_m);
    chk_perf();
  endtask

  logic [N-1:0][1:0]    ty;
  logic [N-1:0][AW-1:0] ad;
  logic [N-1:0][DW-1:0] sd;
  logic [N-1:0]         v;

  initial begin
    rst = 1'b1;
    req_valid = '0; req_type = '0; req_addr = '0;
    snoop_hit = '0; snoop_supply = '0; snoop_data = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_req", mem_req_valid, 0);
    chk("rst_err", err_multi_owner, 0);
    rst = 1'b0;
    ad = '0; sd = '0;

    // all four request continuously: order 0,1,2,3,0
    for (int t = 0; t < 5; t++) begin
      ty = {4{2'b01}};
      for (int i = 0; i < N; i++) ad[i] = AW'(64'h2000 + 64'(i) * 64);
      run_txn(4'hF, ty, ad, '0, '0, sd);
    end
    // core 2 BusRd from memory, no hits
    ty = '0; ty[2] = 2'b01; ad[2] = 64'h1000;
    run_txn(4'b0100, ty, ad, '0, '0, sd);
    // core 0 BusRd, core 3 supplies
    ty = '0; ty[0] = 2'b01; ad[0] = 64'h40;
    sd[3] = {64{8'h55}};
    run_txn(4'b0001, ty, ad, 4'b1000, 4'b1000, sd);
    // core 1 BusRdX, cores 0 and 2 both supply
    ty = '0; ty[1] = 2'b10; ad[1] = 64'h80;
    sd[0] = {64{8'h11}}; sd[2] = {64{8'h22}};
    run_txn(4'b0010, ty, ad, 4'b0101, 4'b0101, sd);
    // core 3 BusUpgr
    ty = '0; ty[3] = 2'b11; ad[3] = 64'hC0;
    run_txn(4'b1000, ty, ad, 4'b0011, 4'b0000, sd);

    for (int t = 0; t < 40; t++) begin
      int r;
      v = N'($urandom);
      for (int i = 0; i < N; i++) begin
        ty[i] = 2'($urandom);
        ad[i] = {$urandom, $urandom};
        for (int w = 0; w < DW/32; w++) sd[i][w*32 +: 32] = $urandom;
      end
      r = $urandom_range(0, N-1);
      v[r] = 1'b1;
      if (ty[r] == 2'b00) ty[r] = 2'b01;
      run_txn(v, ty, ad, N'($urandom), N'($urandom & $urandom), sd);
    end

    // reset while waiting on memory
    @(negedge clk);
    req_valid = 4'b0100; req_type = '0; req_type[2] = 2'b01; req_addr[2] = 64'h1000;
    snoop_supply = '0; snoop_hit = '0;
    @(negedge clk);
    req_valid = '0;
    for (int c = 0; c < 20 && !mem_req_valid; c++) @(negedge clk);
    chk("rst_test_mem_req", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_resp", resp_valid, 0);
    chk("rst_mid_err", err_multi_owner, 0);
    @(negedge clk);
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = {64{8'hAA}};
    begin
      logic [N-1:0] seen;
      seen = '0;
      @(negedge clk); seen |= resp_valid;
      mem_resp_valid = 1'b0;
      repeat (3) begin @(negedge clk); seen |= resp_valid; end
      chk("rst_no_resp", seen, 0);
    end
    ptr_m = 0; err_m = 1'b0; txn_m = 0; c2c_m = 0;
    chk_perf();
    ty = {4{2'b01}};
    run_txn(4'hF, ty, ad, '0, '0, sd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
